// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS decode stage: opcodes, control
// encodings and the packed control bundle carried through ID/EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef enum logic [1:0] {
    LM_WORD = 2'd0,
    LM_HALF = 2'd1,
    LM_BYTE = 2'd2
  } load_mode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_RTYPE = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    load_mode_e load_mode;
    alu_op_e    alu_op;
  } ctrl_t;

  // Unknown opcodes decode to an all-zero bundle, i.e. a NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      OP_LW, OP_LH, OP_LB: begin
        c.alu_src    = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_op     = ALU_ADD;
        c.load_mode  = (op == OP_LH) ? LM_HALF :
                       (op == OP_LB) ? LM_BYTE : LM_WORD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OR;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile_byp.sv
// Register file with synchronous clear and same-cycle writeback bypass.
// Register 0 is not stored and always reads as zero.
module id_regfile_byp #(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (we && (waddr == RA_W'(i))) regs_d[i] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [RA_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ra == RA_W'(i)) v = regs_q[i];
    end
    // A write landing this cycle is forwarded so ID sees the newest value.
    if (we && (ra != '0) && (waddr == ra)) v = wdata;
    return v;
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
  end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: bypassed register file, control decode, immediate
// extension, load-use stall and flush handling, and the ID/EX register.
module id_stage_hz
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] in_new_pc_value,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_rt,
  input  logic              flush,
  output logic              stall,
  output logic              valid,
  output logic [RA_W-1:0]   instr_bits_15_11,
  output logic [RA_W-1:0]   instr_bits_20_16,
  output logic [RA_W-1:0]   instr_bits_25_21,
  output logic [DATA_W-1:0] extended_bits,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] new_pc_value,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              MemToReg,
  output logic              Branch,
  output logic [1:0]        load_mode,
  output logic [2:0]        ALUOp
);

  logic [5:0]        opcode;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              uses_rt, hz, bubble;

  assign opcode = instruction[31:26];
  assign rs     = RA_W'(instruction[25:21]);
  assign rt     = RA_W'(instruction[20:16]);
  assign rd     = RA_W'(instruction[15:11]);
  assign imm    = instruction[15:0];

  id_regfile_byp #(
    .DATA_W  (DATA_W),
    .RA_W    (RA_W),
    .NUM_REGS(NUM_REGS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rf_rd1),
    .rdata2(rf_rd2)
  );

  // Only R-type, sw and beq actually read rt; for loads/immediates rt is a destination.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign hz      = in_valid && ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  assign stall   = hz && !flush;
  assign bubble  = flush || hz || !in_valid;

  ctrl_t             ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [RA_W-1:0]   rd_d, rd_q, rt_d, rt_q, rs_d, rs_q;
  logic [DATA_W-1:0] ext_d, ext_q, rd1_d, rd1_q, rd2_d, rd2_q, pc_d, pc_q;

  always_comb begin
    ctrl_d  = decode_ctrl(opcode);
    valid_d = 1'b1;
    rd_d    = rd;
    rt_d    = rt;
    rs_d    = rs;
    rd1_d   = rf_rd1;
    rd2_d   = rf_rd2;
    pc_d    = in_new_pc_value;
    if ((opcode == OP_ANDI) || (opcode == OP_ORI)) ext_d = {{(DATA_W-16){1'b0}}, imm};
    else                                           ext_d = {{(DATA_W-16){imm[15]}}, imm};
    if (bubble) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      rt_q    <= '0;
      rs_q    <= '0;
      ext_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      pc_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
      rs_q    <= rs_d;
      ext_q   <= ext_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      pc_q    <= pc_d;
    end
  end

  assign valid            = valid_q;
  assign instr_bits_15_11 = rd_q;
  assign instr_bits_20_16 = rt_q;
  assign instr_bits_25_21 = rs_q;
  assign extended_bits    = ext_q;
  assign read_data1       = rd1_q;
  assign read_data2       = rd2_q;
  assign new_pc_value     = pc_q;
  assign RegDst           = ctrl_q.reg_dst;
  assign RegWrite         = ctrl_q.reg_write;
  assign ALUSrc           = ctrl_q.alu_src;
  assign MemWrite         = ctrl_q.mem_write;
  assign MemRead          = ctrl_q.mem_read;
  assign MemToReg         = ctrl_q.mem_to_reg;
  assign Branch           = ctrl_q.branch;
  assign load_mode        = ctrl_q.load_mode;
  assign ALUOp            = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: directed plan vectors then random traffic,
// checked against an instruction-level reference model.
module tb_id_stage_hz;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] in_new_pc_value;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        flush;
  logic        stall, valid;
  logic [4:0]  instr_bits_15_11, instr_bits_20_16, instr_bits_25_21;
  logic [31:0] extended_bits, read_data1, read_data2, new_pc_value;
  logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
  logic [1:0]  load_mode;
  logic [2:0]  ALUOp;

  id_stage_hz #(.DATA_W(32), .RA_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .in_new_pc_value(in_new_pc_value), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .stall(stall), .valid(valid), .instr_bits_15_11(instr_bits_15_11),
    .instr_bits_20_16(instr_bits_20_16), .instr_bits_25_21(instr_bits_25_21),
    .extended_bits(extended_bits), .read_data1(read_data1), .read_data2(read_data2),
    .new_pc_value(new_pc_value), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .Branch(Branch), .load_mode(load_mode), .ALUOp(ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        stall;
    bit        valid;
    bit        chk_data;
    bit [6:0]  ctl;
    bit [1:0]  lm;
    bit [2:0]  aop;
    bit [4:0]  rd, rt, rs;
    bit [31:0] ext, r1, r2, pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf[32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, req);
    end
  endtask

  // Control table in output order {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch}.
  task automatic ref_ctrl(input bit [5:0] op, output bit [6:0] ctl,
                          output bit [1:0] lm, output bit [2:0] aop);
    ctl = 7'b0; lm = 2'd0; aop = 3'd0;
    case (op)
      6'h00: begin ctl = 7'b1100000; aop = 3'd2; end
      6'h23: begin ctl = 7'b0110110; lm = 2'd0; end
      6'h21: begin ctl = 7'b0110110; lm = 2'd1; end
      6'h20: begin ctl = 7'b0110110; lm = 2'd2; end
      6'h2B: begin ctl = 7'b0011000; end
      6'h04: begin ctl = 7'b0000001; aop = 3'd1; end
      6'h08: begin ctl = 7'b0110000; aop = 3'd0; end
      6'h0C: begin ctl = 7'b0110000; aop = 3'd3; end
      6'h0D: begin ctl = 7'b0110000; aop = 3'd4; end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input bit [4:0] a, input bit we,
                                             input bit [4:0] wa, input bit [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return rf[a];
  endfunction

  task automatic apply(input bit r, input bit iv, input bit [31:0] ins, input bit [31:0] pc,
                       input bit we, input bit [4:0] wa, input bit [31:0] wd,
                       input bit emr, input bit [4:0] ert, input bit fl);
    exp_t e;
    bit [5:0] op;
    bit [4:0] s, t;
    bit urt, hzm;
    @(negedge clk);
    rst = r; in_valid = iv; instruction = ins; in_new_pc_value = pc;
    wb_we = we; wb_addr = wa; wb_data = wd; ex_mem_read = emr; ex_rt = ert; flush = fl;
    op = ins[31:26]; s = ins[25:21]; t = ins[20:16];
    urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    hzm = iv && emr && (ert != 0) && ((ert == s) || (urt && ert == t));
    e = '{default: 0};
    e.stall = hzm && !fl;
    if (r) begin
      e.chk_data = 1;
    end else if (!(fl || hzm || !iv)) begin
      e.valid = 1; e.chk_data = 1;
      ref_ctrl(op, e.ctl, e.lm, e.aop);
      e.rd = ins[15:11]; e.rt = t; e.rs = s; e.pc = pc;
      e.ext = (op == 6'h0C || op == 6'h0D) ? {16'h0, ins[15:0]}
                                            : {{16{ins[15]}}, ins[15:0]};
      e.r1 = model_read(s, we, wa, wd);
      e.r2 = model_read(t, we, wa, wd);
    end
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    end else if (we && wa != 0) begin
      rf[wa] = wd;
    end
  endtask

  function automatic bit [31:0] rtype(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
    return {6'h00, s, t, d, 11'h020};
  endfunction

  function automatic bit [31:0] itype(input bit [5:0] op, input bit [4:0] s,
                                      input bit [4:0] t, input bit [15:0] im);
    return {op, s, t, im};
  endfunction

  // Monitor: stall sampled mid-cycle, ID/EX sampled just after the edge.
  always begin
    exp_t e;
    logic st;
    @(negedge clk);
    #2 st = stall;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall", {31'b0, st}, {31'b0, e.stall});
      chk("valid", {31'b0, valid}, {31'b0, e.valid});
      chk("ctrl", {25'b0, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch},
          {25'b0, e.ctl});
      chk("load_mode", {30'b0, load_mode}, {30'b0, e.lm});
      chk("ALUOp", {29'b0, ALUOp}, {29'b0, e.aop});
      if (e.chk_data) begin
        chk("rd", {27'b0, instr_bits_15_11}, {27'b0, e.rd});
        chk("rt", {27'b0, instr_bits_20_16}, {27'b0, e.rt});
        chk("rs", {27'b0, instr_bits_25_21}, {27'b0, e.rs});
        chk("extended_bits", extended_bits, e.ext);
        chk("read_data1", read_data1, e.r1);
        chk("read_data2", read_data2, e.r2);
        chk("new_pc_value", new_pc_value, e.pc);
      end
    end
  end

  localparam bit [5:0] OPS[10] = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h2B,
                                   6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F};

  initial begin
    bit [5:0] op;
    int wait_cnt;
    rst = 1; in_valid = 0; instruction = 0; in_new_pc_value = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_mem_read = 0; ex_rt = 0; flush = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, rtype(5, 0, 1), 32'h4, 0, 0, 0, 0, 0, 0);
    apply(0, 1, rtype(3, 0, 1), 32'h8, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    apply(0, 1, rtype(4, 5, 2), 32'hC, 0, 0, 0, 1, 4, 0);
    apply(0, 1, itype(6'h2B, 1, 4, 16'h0010), 32'h10, 0, 0, 0, 1, 4, 0);
    apply(0, 1, itype(6'h08, 6, 2, 16'h0004), 32'h14, 0, 0, 0, 1, 4, 0);
    apply(0, 1, rtype(4, 5, 2), 32'h18, 0, 0, 0, 1, 4, 1);
    apply(0, 1, itype(6'h08, 3, 7, 16'hFFFC), 32'h1C, 0, 0, 0, 0, 0, 0);
    apply(0, 1, itype(6'h0D, 3, 7, 16'hFFFC), 32'h20, 0, 0, 0, 0, 0, 0);
    apply(0, 1, rtype(3, 3, 8), 32'h24, 1, 0, 32'h1234, 0, 0, 0);
    apply(0, 1, rtype(0, 3, 9), 32'h28, 0, 0, 0, 0, 0, 0);
    apply(0, 1, itype(6'h20, 3, 10, 16'h8001), 32'h2C, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      op = OPS[$urandom_range(0, 9)];
      apply(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 85),
            {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
            $urandom,
            ($urandom_range(0, 99) < 60),
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 99) < 40),
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 10));
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised next-generation decode stage for the 5-stage MIPS pipeline, between the IF/ID and EX stages.
- Combines a bypassed register file, opcode control decode, sign/zero extension, and an ID/EX pipeline register.
- Adds what the previous ID stage lacks: synchronous reset, load-use hazard detection with stall/bubble insertion, branch flush, valid tracking, and write-before-read bypass.

Parameters:
- DATA_W, 32, datapath and register width
- RA_W, 5, register address width
- NUM_REGS, 32, register count (must be <= 2**RA_W); register 0 reads as zero

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  instruction word from IF/ID
- in_new_pc_value  in  DATA_W  PC+4 from IF/ID
- wb_we  in  1  writeback enable
- wb_addr  in  RA_W  writeback register
- wb_data  in  DATA_W  writeback data
- ex_mem_read  in  1  instruction currently in EX is a load
- ex_rt  in  RA_W  destination (rt) of the load in EX
- flush  in  1  branch taken; squash the instruction in ID
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- valid  out  1  ID/EX holds a real instruction
- instr_bits_15_11, instr_bits_20_16, instr_bits_25_21  out  RA_W each  rd, rt, rs
- extended_bits  out  DATA_W  extended immediate
- read_data1, read_data2  out  DATA_W  rs and rt values
- new_pc_value  out  DATA_W  registered PC+4
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch  out  1 each  control
- load_mode  out  2  0 = word, 1 = half, 2 = byte
- ALUOp  out  3  ALU operation class

Behaviour:
- Register file
  - NUM_REGS x DATA_W; written on the clk edge when wb_we=1 and wb_addr!=0.
  - Reads are combinational. When wb_we=1, wb_addr==read address, and the address is nonzero, the read returns wb_data in the same cycle (bypass).
  - Writes to address 0 are ignored.
- Decode, by opcode:
  - 0x00 R-type: RegDst=1, RegWrite=1, ALUOp=2.
  - 0x23/0x21/0x20 lw/lh/lb: ALUSrc=1, RegWrite=1, MemRead=1, MemToReg=1, ALUOp=0, load_mode=0/1/2.
  - 0x2B sw: ALUSrc=1, MemWrite=1, ALUOp=0.
  - 0x04 beq: Branch=1, ALUOp=1.
  - 0x08 addi: ALUSrc=1, RegWrite=1, ALUOp=0.
  - 0x0C andi: ALUSrc=1, RegWrite=1, ALUOp=3.
  - 0x0D ori: ALUSrc=1, RegWrite=1, ALUOp=4.
  - Any other opcode: all controls 0 (NOP).
- Extension: imm16 is zero-extended for andi/ori and sign-extended to DATA_W otherwise.
- Hazard (combinational):
  - uses_rt = R-type | sw | beq.
  - hz = in_valid & ex_mem_read & ex_rt!=0 & (ex_rt==rs | (uses_rt & ex_rt==rt)).
  - stall = hz & ~flush.
- ID/EX register update, in priority order each clk edge:
  1. rst: every output register cleared to 0, including valid. Register file cleared to 0.
  2. flush or hz or ~in_valid: insert a bubble. valid and all control bits go to 0; data fields may update but are don't-care.
  3. Otherwise: load decoded fields, read data, and extended immediate; valid=1.
- Latency: ID/EX outputs reflect the IF/ID instruction one cycle later.
- Simultaneous events:
  - flush overrides hz: no stall, bubble inserted.
  - Writeback to rs in the same cycle as decode: the bypassed value is captured.
- Reset mid-stall: stall drops with rst only if the hazard inputs also drop. stall is purely a function of its inputs; ID/EX is held cleared while rst=1.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_LH, OP_LB, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI)
  - load_mode encodings
  - ALUOp encodings
  - packed control-bundle typedef
- Sub-module `id_regfile_byp` (parametrised register file with bypass and reset). Decode and hazard logic stay inline.

Test Plan:
- rst=1 for 2 cycles, then reset released -> all outputs 0, valid=0; reading r5 returns 0.
- wb_we=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle as decoding add r1,r3,r0 -> next cycle read_data1=0xDEADBEEF, RegDst=1, ALUOp=2, valid=1.
- ex_mem_read=1, ex_rt=4 while decoding add r2,r4,r5 -> stall=1; next ID/EX valid=0 with all control bits 0. Repeat with sw r4 as the rt operand -> stall=1. Repeat with addi r2,r6,4 (ex_rt=4, so no operand match) -> stall=0.
- The load-use hazard case with flush=1 in the same cycle -> stall=0, bubble inserted, valid=0.
- addi imm=0xFFFC -> extended_bits=0xFFFFFFFC. ori imm=0xFFFC -> extended_bits=0x0000FFFC, ALUOp=4.
- wb_we=1 with wb_addr=0 and wb_data=0x1234 -> a later read of r0 returns 0. lb decode -> load_mode=2, MemRead=1, MemToReg=1.
